// File: rtl/uart_byte_tx.sv
// uart_byte_tx: byte-oriented 8N1 serial transmitter.
// The request is level-sensitive: while `transmit` stays high, frames go out
// back to back, and `data` is sampled at the end of each LOAD window.
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit, 11-bit frame).
module uart_byte_tx #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned LOAD_DELAY   = 4
) (
    input  logic       sys_clk,
    input  logic       uart_reset,
    input  logic       transmit,
    input  logic [7:0] data,
    output logic       TxD,
    output logic       done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, LOAD, START, DATA, STOP, DONE, PARITY
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, LOAD, START, DATA, STOP, DONE
    } state_t;
`endif

    state_t          r_state;
    logic [CW-1:0]   r_clk_cnt;
    logic [7:0]      r_load_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_txd;
    logic            r_done;
    logic            w_bit_end;
    logic            w_load_end;

    assign w_bit_end  = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_load_end = (r_load_cnt == 8'(LOAD_DELAY - 1));

    assign TxD  = r_txd;
    assign done = r_done;

    // Frame sequencer: state, bit timer, latched byte and registered line outputs.
    always_ff @(posedge sys_clk) begin
        if (uart_reset) begin
            r_state    <= IDLE;
            r_clk_cnt  <= '0;
            r_load_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_txd      <= 1'b1;
                    r_done     <= 1'b0;
                    r_clk_cnt  <= '0;
                    r_load_cnt <= '0;
                    if (transmit) begin
                        r_state <= LOAD;
                    end
                end

                LOAD: begin
                    r_txd  <= 1'b1;
                    r_done <= 1'b0;
                    if (!transmit) begin
                        r_state    <= IDLE;
                        r_load_cnt <= '0;
                    end else if (w_load_end) begin
                        // Byte is captured here and held for the whole frame.
                        r_shift    <= data;
                        r_bit_idx  <= '0;
                        r_clk_cnt  <= '0;
                        r_load_cnt <= '0;
                        r_txd      <= 1'b0;
                        r_state    <= START;
                    end else begin
                        r_load_cnt <= r_load_cnt + 8'd1;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_txd     <= r_shift[0];
                        r_state   <= DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_txd   <= ^r_shift;
                            r_state <= PARITY;
`else
                            r_txd   <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= r_shift[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

`ifdef UART_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_txd     <= 1'b1;
                        r_state   <= STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_txd     <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                DONE: begin
                    r_txd <= 1'b1;
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_done    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_txd   <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: self-checking bench for uart_byte_tx (CLKS_PER_BIT=16, LOAD_DELAY=4).
// Honours UART_PARITY_EN in its reference model.
module tb_uart_byte_tx;

    localparam int CPB = 16;
    localparam int LD  = 4;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int LAT    = LD + 1;
    localparam int PERIOD = (FB + 1) * CPB + LD + 1;

    logic       sys_clk = 1'b0;
    logic       uart_reset;
    logic       transmit;
    logic [7:0] data;
    logic       TxD;
    logic       done;

    int total = 0;
    int bad   = 0;

    uart_byte_tx #(
        .CLKS_PER_BIT (CPB),
        .LOAD_DELAY   (LD)
    ) dut (
        .sys_clk    (sys_clk),
        .uart_reset (uart_reset),
        .transmit   (transmit),
        .data       (data),
        .TxD        (TxD),
        .done       (done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0] d;
        int         hold;
        bit         frame;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Expected line level k cycles into a frame whose start bit begins at k=0.
    function automatic logic model_txd(input logic [7:0] b, input int k);
        int bitno;
        bitno = k / CPB;
        if (bitno == 0) return 1'b0;
        if (bitno <= 8) return b[bitno - 1];
        if (FB == 11 && bitno == 9) return ($countones(b) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic wait_start(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (TxD !== 1'b0 && n < bound);
    endtask

    task automatic idle_check(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            chk({tag, "_txd"}, TxD, 1);
            chk({tag, "_done"}, done, 0);
            tick();
        end
    endtask

    // Entered at the first start-bit sample; leaves one sample after done falls.
    task automatic expect_frame(input logic [7:0] b, input int drop_at, input bit scramble,
                                input string tag);
        for (int k = 0; k < (FB + 1) * CPB; k++) begin
            chk({tag, "_txd"}, TxD, model_txd(b, k));
            chk({tag, "_done"}, done, (k >= FB * CPB) ? 1 : 0);
            if (k == drop_at) transmit = 1'b0;
            if (scramble) data = 8'($urandom);
            tick();
        end
        chk({tag, "_done_fall"}, done, 0);
        chk({tag, "_idle_txd"}, TxD, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        int len;
        logic [7:0] q[$];

        vecs[0] = '{8'h41, 6,  1'b1};
        vecs[1] = '{8'h00, 1,  1'b0};
        vecs[2] = '{8'hFF, 4,  1'b0};
        vecs[3] = '{8'h07, 5,  1'b1};
        vecs[4] = '{8'h03, 9,  1'b1};
        vecs[5] = '{8'hA5, 3,  1'b0};
        vecs[6] = '{8'h80, 5,  1'b1};
        vecs[7] = '{8'h7E, 12, 1'b1};

        // Reset held with a pending request: line stays idle, then launch latency.
        uart_reset = 1'b1;
        transmit   = 1'b1;
        data       = 8'h41;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_txd", TxD, 1);
            chk("rst_done", done, 0);
        end
        uart_reset = 1'b0;
        wait_start(LAT + 3, n);
        chk("rst_latency", n, LAT);
        expect_frame(8'h41, 0, 0, "rst_frame");
        idle_check(2 * LD + CPB, "rst_idle");

        // Table: request pulse lengths around the LOAD window boundary.
        foreach (vecs[i]) begin
            data     = vecs[i].d;
            transmit = 1'b1;
            n        = 0;
            seen     = 0;
            while (seen == 0 && n < LAT + 2) begin
                tick();
                n++;
                if (n == vecs[i].hold) transmit = 1'b0;
                if (TxD === 1'b0) seen = 1;
            end
            chk($sformatf("vec%0d_frame", i), seen, vecs[i].frame);
            if (vecs[i].frame) begin
                chk($sformatf("vec%0d_latency", i), n, LAT);
                expect_frame(vecs[i].d, 0, 0, $sformatf("vec%0d", i));
                idle_check(2 * LD + 2, $sformatf("vec%0d_idle", i));
            end else begin
                transmit = 1'b0;
                idle_check(2 * CPB, $sformatf("vec%0d_noframe", i));
            end
        end

        // Back-to-back with data updated two cycles after done falls.
        data     = 8'h33;
        transmit = 1'b1;
        wait_start(LAT + 2, n);
        chk("b2b_latency", n, LAT);
        expect_frame(8'h33, -1, 0, "b2b0");
        idle_check(2, "b2b_gap");
        data = 8'h2C;
        wait_start(LAT + 2, n);
        chk("b2b_spacing", (FB + 1) * CPB + 2 + n, PERIOD);
        expect_frame(8'h2C, 0, 0, "b2b1");
        idle_check(2 * LD + CPB, "b2b_idle");

        // Reset during data bit 3 aborts at once; next request is a fresh frame.
        data     = 8'hA5;
        transmit = 1'b1;
        wait_start(LAT + 2, n);
        chk("abort_latency", n, LAT);
        transmit = 1'b0;
        for (int k = 0; k < 4 * CPB + CPB / 2; k++) tick();
        chk("abort_pre_txd", TxD, 0);
        uart_reset = 1'b1;
        tick();
        chk("abort_txd", TxD, 1);
        chk("abort_done", done, 0);
        uart_reset = 1'b0;
        idle_check(2 * CPB, "abort_idle");
        data     = 8'h5A;
        transmit = 1'b1;
        wait_start(LAT + 2, n);
        chk("fresh_latency", n, LAT);
        expect_frame(8'h5A, 0, 0, "fresh");
        idle_check(2 * LD + 2, "fresh_idle");

        // Random chains; data is scrambled during each frame to prove it is held.
        for (int c = 0; c < 5; c++) begin
            q.delete();
            len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) q.push_back(8'($urandom));
            data     = q[0];
            transmit = 1'b1;
            wait_start(LAT + 2, n);
            chk($sformatf("rnd%0d_latency", c), n, LAT);
            for (int j = 0; j < len; j++) begin
                expect_frame(q[j], (j == len - 1) ? 0 : -1, 1, $sformatf("rnd%0d_%0d", c, j));
                if (j < len - 1) begin
                    data = q[j + 1];
                    wait_start(LAT + 2, n);
                    chk($sformatf("rnd%0d_gap%0d", c, j), (FB + 1) * CPB + n, PERIOD);
                end
            end
            idle_check(2 * LD + 2, $sformatf("rnd%0d_idle", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
